// File: rtl/eig_pkg.sv
// Shared definitions for the QR eigenvalue datapath: matrix geometry, bus type,
// loader FSM encoding and the element bit-offset helper.
package eig_pkg;

  localparam int unsigned N      = 4;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned FRAC_W = 10;
  localparam int unsigned MAT_W  = N * N * DATA_W;

  typedef logic [MAT_W-1:0] mat_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    HOLD,
    RESYNC
  } loader_state_e;

  // Low bit of element (r,c) on the packed matrix bus.
  function automatic int unsigned elem_lo(input int unsigned r, input int unsigned c);
    return DATA_W * (N * r + c);
  endfunction

endpackage

// File: rtl/slot_remap.sv
// Maps a stream slot number to the bit offset of its element on the matrix bus.
// Row-major streams use slot k as (k/N, k%N); column-major streams as (k%N, k/N).
module slot_remap
  import eig_pkg::*;
#(
  parameter int unsigned COL_MAJOR = 0,
  parameter int unsigned CNT_W     = 5,
  parameter int unsigned OFF_W     = 8
) (
  input  logic [CNT_W-1:0] cnt_i,
  output logic [OFF_W-1:0] off_o
);

  int unsigned k;
  int unsigned r;
  int unsigned c;

  // Slot to (row, column), then to bit offset.
  always_comb begin
    k = 32'(cnt_i);
    if (COL_MAJOR != 0) begin
      r = k % N;
      c = k / N;
    end else begin
      r = k / N;
      c = k % N;
    end
    off_o = OFF_W'(elem_lo(r, c));
  end

endmodule

// File: rtl/matrix_loader.sv
// Streams the N*N elements of a matrix in one per beat, packs them into a working
// buffer and publishes the complete matrix on m_matrix with a valid/ready handshake.
// Framing errors (s_last missing or misplaced) set a sticky flag and drop the frame.
module matrix_loader #(
  parameter int unsigned N         = eig_pkg::N,
  parameter int unsigned DATA_W    = eig_pkg::DATA_W,
  parameter int unsigned COL_MAJOR = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_W-1:0]     s_data,
  input  logic                  s_last,
  input  logic                  clear,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [N*N*DATA_W-1:0] m_matrix,
  output logic                  busy,
  output logic                  frame_err,
  input  logic                  err_clr
);
  import eig_pkg::*;

  localparam int unsigned MW    = N * N * DATA_W;
  localparam int unsigned CNT_W = $clog2(N * N + 1);
  localparam int unsigned OFF_W = $clog2(MW);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(N * N - 1);
  localparam logic [CNT_W-1:0] CntMax  = CNT_W'(N * N);

  loader_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [MW-1:0]    work_q, work_d, work_wr;
  logic [MW-1:0]    mat_q, mat_d;
  logic             s_ready_q, s_ready_d;
  logic             m_valid_q, m_valid_d;
  logic             err_q, err_d;
  logic             err_set;
  logic             beat;
  logic [OFF_W-1:0] off;

  slot_remap #(
    .COL_MAJOR(COL_MAJOR),
    .CNT_W    (CNT_W),
    .OFF_W    (OFF_W)
  ) u_slot_remap (
    .cnt_i(cnt_q),
    .off_o(off)
  );

  // Next-state logic: framing FSM, slot counter, buffers and sticky error.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    mat_d   = mat_q;
    err_d   = err_q;
    err_set = 1'b0;
    beat    = s_valid & s_ready_q;
    work_wr = work_q;
    work_wr[off +: DATA_W] = s_data;

    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (beat) begin
            if (s_last) begin
              err_set = 1'b1;
            end else begin
              work_d  = work_wr;
              cnt_d   = CNT_W'(1);
              state_d = FILL;
            end
          end
        end
        FILL: begin
          if (beat) begin
            cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
            if (cnt_q == CntLast) begin
              if (s_last) begin
                // Publish buffer plus final element in one step.
                mat_d   = work_wr;
                state_d = HOLD;
              end else begin
                err_set = 1'b1;
                cnt_d   = '0;
                state_d = RESYNC;
              end
            end else if (s_last) begin
              err_set = 1'b1;
              cnt_d   = '0;
              state_d = IDLE;
            end else begin
              work_d = work_wr;
            end
          end
        end
        HOLD: begin
          if (m_valid_q && m_ready) begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        RESYNC: begin
          if (beat && s_last) begin
            state_d = IDLE;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      endcase

      // A new error outranks a simultaneous clear request.
      if (err_set) begin
        err_d = 1'b1;
      end else if (err_clr) begin
        err_d = 1'b0;
      end
    end

    s_ready_d = (state_d != HOLD);
    m_valid_d = (state_d == HOLD);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      work_q    <= '0;
      mat_q     <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      mat_q     <= mat_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      err_q     <= err_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign m_valid   = m_valid_q;
  assign m_matrix  = mat_q;
  assign frame_err = err_q;
  assign busy      = (state_q == FILL) || (state_q == HOLD);

endmodule
